// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM burst arbiter slice.
//   arb_state_t     : arbiter FSM states
//   DEF_BLOCK_SIZE  : default words per burst
//   MST_DC / MST_IC : master IDs held by the round-robin last-grant pointer
//                     (used only when DRAM_ARB_RR_EN is defined)
package dram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GNT_DW = 3'd1,
        GNT_DR = 3'd2,
        GNT_IR = 3'd3,
        HOLD   = 3'd4
    } arb_state_t;

    localparam int unsigned DEF_BLOCK_SIZE = 8;

    localparam logic MST_DC = 1'b0;
    localparam logic MST_IC = 1'b1;

endpackage

// File: rtl/dram_burst_counter.sv
// Beat counter and address generator for one burst.
//   load       : latch load_addr as the burst base and clear the beat counter
//   advance    : one beat completed, step the counter
//   beat_addr  : base + beat, modulo 2^ADDR_W
//   last_beat  : the counter is on the final beat of the burst
module dram_burst_counter
    import dram_arb_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              advance,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              last_beat
);

    localparam int unsigned BEAT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;

    always_comb begin
        base_d = base_q;
        beat_d = beat_q;
        if (load) begin
            base_d = load_addr;
            beat_d = '0;
        end else if (advance) begin
            beat_d = beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            base_q <= '0;
            beat_q <= '0;
        end else begin
            base_q <= base_d;
            beat_q <= beat_d;
        end
    end

    // No carry check: the address simply wraps at 2^ADDR_W.
    assign beat_addr = base_q + ADDR_W'(beat_q);
    assign last_beat = (beat_q == BEAT_W'(BLOCK_SIZE - 1));

endmodule

// File: rtl/dram_burst_arbiter.sv
// Shares one main-memory port between the I-cache (refill) and the D-cache
// (write-back + refill), granting whole BLOCK_SIZE-word bursts.
//   ic_rd_*  : I-cache refill request/address, returned data and valid
//   dc_wr_*  : D-cache write-back request/address/data, beat-accepted valid
//   dc_rd_*  : D-cache refill request/address, returned data and valid
//   mem_*    : memory beat request, write enable, address, data, completion
// Build option: DRAM_ARB_RR_EN alternates grants between the D-cache and the
// I-cache (write before read inside the D-cache turn); undefined gives fixed
// priority dc_wr > dc_rd > ic_rd.
module dram_burst_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              ic_rd_req,
    input  logic [ADDR_W-1:0] ic_rd_addr,
    output logic [31:0]       ic_rd_data,
    output logic              ic_rd_val,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [31:0]       dc_wr_data,
    output logic              dc_wr_val,
    input  logic              dc_rd_req,
    input  logic [ADDR_W-1:0] dc_rd_addr,
    output logic [31:0]       dc_rd_data,
    output logic              dc_rd_val,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_val
);

    arb_state_t        state_q, state_d;
    arb_state_t        grant_st;
    logic              wr_gap_q, wr_gap_d;
    logic              load;
    logic [ADDR_W-1:0] load_addr;
    logic              last_beat;

    // Arbitration result, only acted upon in IDLE.
`ifdef DRAM_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        grant_st = IDLE;
        last_d   = last_q;
        if (ic_rd_req && (last_q == MST_DC || !(dc_wr_req || dc_rd_req)))
            grant_st = GNT_IR;
        else if (dc_wr_req)
            grant_st = GNT_DW;
        else if (dc_rd_req)
            grant_st = GNT_DR;
        if (state_q == IDLE && grant_st != IDLE)
            last_d = (grant_st == GNT_IR) ? MST_IC : MST_DC;
    end

    // Reset value lets the D-cache win the first contested grant.
    always_ff @(posedge clock) begin
        if (rst) last_q <= MST_IC;
        else     last_q <= last_d;
    end
`else
    always_comb begin
        grant_st = IDLE;
        if (dc_wr_req)
            grant_st = GNT_DW;
        else if (dc_rd_req)
            grant_st = GNT_DR;
        else if (ic_rd_req)
            grant_st = GNT_IR;
    end
`endif

    always_comb begin
        state_d   = state_q;
        wr_gap_d  = 1'b0;
        load      = 1'b0;
        load_addr = '0;
        mem_req   = 1'b0;
        mem_wren  = 1'b0;
        ic_rd_val = 1'b0;
        dc_rd_val = 1'b0;
        dc_wr_val = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_st != IDLE) begin
                    state_d = grant_st;
                    load    = 1'b1;
                    case (grant_st)
                        GNT_DW:  load_addr = dc_wr_addr;
                        GNT_DR:  load_addr = dc_rd_addr;
                        default: load_addr = ic_rd_addr;
                    endcase
                    // First write cycle is a gap: the cache's word register
                    // is not yet valid.
                    wr_gap_d = (grant_st == GNT_DW);
                end
            end
            GNT_DW: begin
                mem_wren = 1'b1;
                mem_req  = !wr_gap_q;
                if (mem_req && mem_val) begin
                    dc_wr_val = 1'b1;
                    wr_gap_d  = 1'b1;
                    if (last_beat) state_d = HOLD;
                end
            end
            GNT_DR: begin
                mem_req = 1'b1;
                if (mem_val) begin
                    dc_rd_val = 1'b1;
                    if (last_beat) state_d = HOLD;
                end
            end
            GNT_IR: begin
                mem_req = 1'b1;
                if (mem_val) begin
                    ic_rd_val = 1'b1;
                    if (last_beat) state_d = HOLD;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_gap_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_gap_q <= wr_gap_d;
        end
    end

    dram_burst_counter #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .ADDR_W     (ADDR_W)
    ) u_counter (
        .clock     (clock),
        .rst       (rst),
        .load      (load),
        .load_addr (load_addr),
        .advance   (mem_req && mem_val),
        .beat_addr (mem_addr),
        .last_beat (last_beat)
    );

    assign ic_rd_data  = mem_rd_data;
    assign dc_rd_data  = mem_rd_data;
    assign mem_wr_data = dc_wr_data;

endmodule

// File: tb/tb_dram_burst_arbiter.sv
module tb_dram_burst_arbiter;

    localparam logic [31:0] RD_KEY = 32'h5A5A_0000;
    localparam logic [31:0] WR_KEY = 32'hC0DE_0000;

    logic        clock = 1'b0;
    logic        rst;
    logic        ic_rd_req;
    logic [31:0] ic_rd_addr;
    logic [31:0] ic_rd_data;
    logic        ic_rd_val;
    logic        dc_wr_req;
    logic [31:0] dc_wr_addr;
    logic [31:0] dc_wr_data;
    logic        dc_wr_val;
    logic        dc_rd_req;
    logic [31:0] dc_rd_addr;
    logic [31:0] dc_rd_data;
    logic        dc_rd_val;
    logic        mem_req;
    logic        mem_wren;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_val;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] wr_idx;

    always #5 clock = ~clock;

    dram_burst_arbiter #(
        .BLOCK_SIZE (8),
        .ADDR_W     (32)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .ic_rd_req   (ic_rd_req),
        .ic_rd_addr  (ic_rd_addr),
        .ic_rd_data  (ic_rd_data),
        .ic_rd_val   (ic_rd_val),
        .dc_wr_req   (dc_wr_req),
        .dc_wr_addr  (dc_wr_addr),
        .dc_wr_data  (dc_wr_data),
        .dc_wr_val   (dc_wr_val),
        .dc_rd_req   (dc_rd_req),
        .dc_rd_addr  (dc_rd_addr),
        .dc_rd_data  (dc_rd_data),
        .dc_rd_val   (dc_rd_val),
        .mem_req     (mem_req),
        .mem_wren    (mem_wren),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_val     (mem_val)
    );

    // D-cache write word register: steps to the next word after each accepted beat.
    always @(posedge clock) begin
        if (rst)            wr_idx <= '0;
        else if (dc_wr_val) wr_idx <= wr_idx + 1;
    end
    assign dc_wr_data  = WR_KEY + wr_idx;
    // Memory returns a keyed copy of the address it was asked for.
    assign mem_rd_data = mem_addr ^ RD_KEY;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    // {mem_req, mem_wren, ic_rd_val, dc_rd_val, dc_wr_val}
    task automatic chk_flags(input string tag, input logic [4:0] exp);
        chk(tag, {27'b0, mem_req, mem_wren, ic_rd_val, dc_rd_val, dc_wr_val}, {27'b0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ic_rd_req = 1'b0; dc_wr_req = 1'b0; dc_rd_req = 1'b0;
        ic_rd_addr = '0; dc_wr_addr = '0; dc_rd_addr = '0;
        mem_val = 1'b1;
        tick();
        settle();
        chk_flags("reset_flags", 5'b00000);
        chk("reset_addr", mem_addr, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    // n read beats with mem_val high every cycle, starting in the grant cycle.
    task automatic read_beats(input string tag, input bit to_ic, input logic [31:0] base,
                              input int unsigned n);
        logic [31:0] a;
        for (int unsigned i = 0; i < n; i++) begin
            settle();
            a = base + i;
            chk_flags({tag, "_flags"}, to_ic ? 5'b10100 : 5'b10010);
            chk({tag, "_addr"}, mem_addr, a);
            chk({tag, "_data"}, to_ic ? ic_rd_data : dc_rd_data, a ^ RD_KEY);
            tick();
        end
    endtask

    // Eight write beats, each preceded by a gap cycle with mem_req low.
    task automatic write_beats(input string tag, input logic [31:0] base);
        for (int unsigned i = 0; i < 8; i++) begin
            settle();
            chk_flags({tag, "_gap"}, 5'b01000);
            tick();
            settle();
            chk_flags({tag, "_beat"}, 5'b11001);
            chk({tag, "_addr"}, mem_addr, base + i);
            chk({tag, "_wdata"}, mem_wr_data, WR_KEY + i);
            tick();
        end
    endtask

    initial begin
        // I-cache only
        do_reset();
        ic_rd_req = 1'b1; ic_rd_addr = 32'h100;
        settle(); chk_flags("ic_idle", 5'b00000);
        tick();
        read_beats("ic", 1'b1, 32'h100, 8);
        settle(); chk_flags("ic_hold", 5'b00000);
        tick();
        ic_rd_req = 1'b0;
        settle(); chk_flags("ic_idle2", 5'b00000);
        tick();
        settle(); chk_flags("ic_idle3", 5'b00000);

        // D-cache write-back
        do_reset();
        dc_wr_req = 1'b1; dc_wr_addr = 32'h40;
        settle(); chk_flags("wb_idle", 5'b00000);
        tick();
        write_beats("wb", 32'h40);
        settle(); chk_flags("wb_hold", 5'b00000);
        tick();
        dc_wr_req = 1'b0;
        settle(); chk_flags("wb_idle2", 5'b00000);

        // Simultaneous D-cache and I-cache refills
        do_reset();
        dc_rd_req = 1'b1; dc_rd_addr = 32'h300;
        ic_rd_req = 1'b1; ic_rd_addr = 32'h180;
        settle(); chk_flags("both_idle", 5'b00000);
        tick();
        read_beats("both_dc", 1'b0, 32'h300, 8);
        settle(); chk_flags("both_hold", 5'b00000);
        tick();
        dc_rd_req = 1'b0;
        settle(); chk_flags("both_rearb", 5'b00000);
        tick();
        read_beats("both_ic", 1'b1, 32'h180, 8);
        settle(); chk_flags("both_hold2", 5'b00000);
        tick();
        ic_rd_req = 1'b0;

        // Dirty miss: write-back then refill, I-cache waiting throughout
        do_reset();
        dc_wr_req = 1'b1; dc_wr_addr = 32'h80;
        ic_rd_req = 1'b1; ic_rd_addr = 32'h500;
        tick();
        write_beats("wtr_wr", 32'h80);
        settle(); chk_flags("wtr_hold", 5'b00000);
        tick();
        dc_wr_req = 1'b0; dc_rd_req = 1'b1; dc_rd_addr = 32'h80;
        settle(); chk_flags("wtr_idle", 5'b00000);
        tick();
        read_beats("wtr_rd", 1'b0, 32'h80, 8);
        dc_rd_req = 1'b0; ic_rd_req = 1'b0;

        // Reset at beat 4 of a read, then restart from beat 0
        do_reset();
        ic_rd_req = 1'b1; ic_rd_addr = 32'h200;
        tick();
        read_beats("rst_pre", 1'b1, 32'h200, 4);
        rst = 1'b1;
        tick();
        settle();
        chk_flags("rst_mid_flags", 5'b00000);
        chk("rst_mid_addr", mem_addr, 32'h0);
        tick();
        rst = 1'b0;
        settle(); chk_flags("rst_idle", 5'b00000);
        tick();
        read_beats("rst_post", 1'b1, 32'h200, 8);
        ic_rd_req = 1'b0;

        // Base address wrap
        do_reset();
        ic_rd_req = 1'b1; ic_rd_addr = 32'hFFFF_FFFC;
        tick();
        read_beats("wrap", 1'b1, 32'hFFFF_FFFC, 7);
        settle(); chk("wrap_beat7", mem_addr, 32'h0000_0003);
        tick();
        settle(); chk_flags("wrap_hold", 5'b00000);
        ic_rd_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
